// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF->ID pipeline register built as a 2-entry skid buffer.
// The main entry drives id_*. The skid entry absorbs one beat while ID stalls,
// so if_ready comes from a flop and has no combinational path from id_ready.
// Flush squashes everything that is buffered.
// Optional build macro: IF_ID_PERF_CNT_EN adds the stall_cnt and flush_cnt
// performance counters. Datapath behaviour is identical with or without it.
module if_id_skid_reg #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_pc_plus4,
  input  logic [XLEN-1:0] if_instruction,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [XLEN-1:0] id_instruction
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_reg;
  logic [XLEN-1:0] skid_pc_reg;
  logic [XLEN-1:0] skid_pc_plus4_reg;
  logic [XLEN-1:0] skid_instr_reg;

  // Handshake qualifiers. Both use only registered outputs on this side.
  // Because of that, id_ready has no effect while id_valid is low.
  logic acc;
  logic deq;
  assign acc = if_valid & if_ready;
  assign deq = id_valid & id_ready;

  // Buffer FSM. The main entry and the skid entry are updated here.
  // All outputs are registered in this block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= EMPTY;
      id_valid          <= 1'b0;
      if_ready          <= 1'b1;
      id_pc             <= '0;
      id_pc_plus4       <= '0;
      id_instruction    <= NOP_INSTR;
      skid_pc_reg       <= '0;
      skid_pc_plus4_reg <= '0;
      skid_instr_reg    <= '0;
    end else if (flush) begin
      // Redirect: drop everything, including a beat offered this cycle
      state_reg         <= EMPTY;
      id_valid          <= 1'b0;
      if_ready          <= 1'b1;
      id_pc             <= '0;
      id_pc_plus4       <= '0;
      id_instruction    <= NOP_INSTR;
      skid_pc_reg       <= '0;
      skid_pc_plus4_reg <= '0;
      skid_instr_reg    <= '0;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (acc) begin
            state_reg      <= ONE;
            id_valid       <= 1'b1;
            id_pc          <= if_pc;
            id_pc_plus4    <= if_pc_plus4;
            id_instruction <= if_instruction;
          end
        end
        ONE: begin
          if (acc && deq) begin
            id_pc          <= if_pc;
            id_pc_plus4    <= if_pc_plus4;
            id_instruction <= if_instruction;
          end else if (acc) begin
            // ID is stalled: park the new beat in the skid entry and stop IF
            state_reg         <= FULL;
            if_ready          <= 1'b0;
            skid_pc_reg       <= if_pc;
            skid_pc_plus4_reg <= if_pc_plus4;
            skid_instr_reg    <= if_instruction;
          end else if (deq) begin
            state_reg      <= EMPTY;
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_pc_plus4    <= '0;
            id_instruction <= NOP_INSTR;
          end
        end
        FULL: begin
          if (deq) begin
            // Promote the skid entry to main; order is preserved
            state_reg         <= ONE;
            if_ready          <= 1'b1;
            id_pc             <= skid_pc_reg;
            id_pc_plus4       <= skid_pc_plus4_reg;
            id_instruction    <= skid_instr_reg;
            skid_pc_reg       <= '0;
            skid_pc_plus4_reg <= '0;
            skid_instr_reg    <= '0;
          end
        end
        default: begin
          state_reg      <= EMPTY;
          id_valid       <= 1'b0;
          if_ready       <= 1'b1;
          id_pc          <= '0;
          id_pc_plus4    <= '0;
          id_instruction <= NOP_INSTR;
        end
      endcase
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  // Performance counters: free-running and wrapping. Only rst clears them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_valid && !id_ready) stall_cnt <= stall_cnt + 32'd1;
      if (flush)                 flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb_if_id_skid_reg: a table of directed vectors, then random traffic checked
// against a queue-based scoreboard.
// The perf counter sequence runs only when IF_ID_PERF_CNT_EN is defined.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_pc = '0;
  logic [31:0] if_pc_plus4 = '0;
  logic [31:0] if_instruction = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instruction;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  if_id_skid_reg dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instruction (if_instruction),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_instruction (id_instruction)
`ifdef IF_ID_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] ins;
  } entry_t;

  // Scoreboard: beats accepted but not yet consumed, oldest first
  entry_t sb_q[$];

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic        idr;
    logic [31:0] pc;
    logic [31:0] ins;
    logic        ev;
    logic        er;
    logic [31:0] epc;
    logic [31:0] eins;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, update the scoreboard at the edge, and settle 1 time unit after it
  task automatic step(input logic r, input logic f, input logic iv, input logic idr,
                      input logic [31:0] pc, input logic [31:0] ins);
    bit     acc;
    bit     deq;
    entry_t e;
    @(negedge clk);
    rst            = r;
    flush          = f;
    if_valid       = iv;
    id_ready       = idr;
    if_pc          = pc;
    if_pc_plus4    = pc + 32'd4;
    if_instruction = ins;
    @(posedge clk);
    acc = iv && (sb_q.size() < 2);
    deq = (sb_q.size() > 0) && idr;
    if (!r || f) begin
      sb_q.delete();
    end else begin
      if (deq) void'(sb_q.pop_front());
      if (acc) begin
        e.pc  = pc;
        e.p4  = pc + 32'd4;
        e.ins = ins;
        sb_q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic chk_model(input int cyc);
    logic [31:0] epc;
    logic [31:0] ep4;
    logic [31:0] eins;
    epc  = (sb_q.size() > 0) ? sb_q[0].pc  : 32'd0;
    ep4  = (sb_q.size() > 0) ? sb_q[0].p4  : 32'd0;
    eins = (sb_q.size() > 0) ? sb_q[0].ins : NOP;
    chk("rnd_id_valid", {31'd0, id_valid}, {31'd0, sb_q.size() > 0});
    chk("rnd_if_ready", {31'd0, if_ready}, {31'd0, sb_q.size() < 2});
    chk("rnd_id_pc", id_pc, epc);
    chk("rnd_id_pc_plus4", id_pc_plus4, ep4);
    chk("rnd_id_instr", id_instruction, eins);
    $display("rnd cyc %0d: v=%0b r=%0b pc=%h ins=%h depth=%0d",
             cyc, id_valid, if_ready, id_pc, id_instruction, sb_q.size());
  endtask

  initial begin
    //          rst flsh iv idr pc           ins            ev er epc          eins
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,  NOP};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,  NOP};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0,   32'h00500093, 1'b1, 1'b1, 32'h0,  32'h00500093};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h4,   32'h00600113, 1'b1, 1'b1, 32'h4,  32'h00600113};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h8,   32'h00700193, 1'b1, 1'b1, 32'h8,  32'h00700193};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hC,   32'h00800213, 1'b1, 1'b1, 32'hC,  32'h00800213};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0,  NOP};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10,  32'h01000093, 1'b1, 1'b1, 32'h10, 32'h01000093};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h14,  32'h01400093, 1'b1, 1'b0, 32'h10, 32'h01000093};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h18,  32'h01800093, 1'b1, 1'b0, 32'h10, 32'h01000093};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18,  32'h01800093, 1'b1, 1'b1, 32'h14, 32'h01400093};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h18,  32'h01800093, 1'b1, 1'b1, 32'h18, 32'h01800093};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0,  NOP};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h20,  32'h02000093, 1'b1, 1'b1, 32'h20, 32'h02000093};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h24,  32'h02400093, 1'b1, 1'b0, 32'h20, 32'h02000093};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h28,  32'h02800093, 1'b0, 1'b1, 32'h0,  NOP};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 32'h0,  NOP};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h30,  32'h03000093, 1'b1, 1'b1, 32'h30, 32'h03000093};
    vecs[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h34,  32'h03400093, 1'b0, 1'b1, 32'h0,  NOP};

    // Directed vectors: reset, streaming, skid, flush in FULL, flush with reset
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].idr, vecs[i].pc, vecs[i].ins);
      chk($sformatf("vec%0d_id_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_if_ready", i), {31'd0, if_ready}, {31'd0, vecs[i].er});
      chk($sformatf("vec%0d_id_pc", i), id_pc, vecs[i].epc);
      chk($sformatf("vec%0d_id_pc_plus4", i), id_pc_plus4,
          vecs[i].ev ? vecs[i].epc + 32'd4 : 32'd0);
      chk($sformatf("vec%0d_id_instr", i), id_instruction, vecs[i].eins);
      $display("vec %0d: rst=%0b flush=%0b iv=%0b idr=%0b pc_in=%h -> v=%0b r=%0b pc=%h ins=%h",
               i, vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].idr, vecs[i].pc,
               id_valid, if_ready, id_pc, id_instruction);
    end
`ifdef IF_ID_PERF_CNT_EN
    chk("rst_flush_cnt", flush_cnt, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
`endif

    // Random traffic against the scoreboard
    for (int c = 0; c < 300; c++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
           $urandom(), $urandom());
      chk_model(c);
    end

    // Perf counters: 5 stall cycles, 2 flushes, then wrap from all-ones
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h04000093);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
    chk("perf_state_empty", {31'd0, id_valid}, 32'd0);
`ifdef IF_ID_PERF_CNT_EN
    chk("perf_stall_cnt", stall_cnt, 32'd5);
    chk("perf_flush_cnt", flush_cnt, 32'd2);
    $display("perf: stall_cnt=%0d flush_cnt=%0d", stall_cnt, flush_cnt);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h04400093);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("perf_stall_wrap", stall_cnt, 32'd0);
    $display("perf wrap: stall_cnt=%h", stall_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
